// File: rtl/dice_dispatch_pkg.sv
// Shared types for the DICE thread dispatcher.
// State encoding and thread-ID sizing used by the issue stage.
package dice_dispatch_pkg;

  localparam int DISP_NUM_THREADS = 512;
  localparam int DISP_TID_WIDTH   = $clog2(DISP_NUM_THREADS);

  typedef logic [DISP_TID_WIDTH-1:0] tid_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } dispatch_state_e;

endpackage

// File: rtl/dice_lsb_finder.sv
// Lowest-set-bit encoder built as a balanced binary tree.
// Lower half wins at each node so the overall result is the minimum index.
module dice_lsb_finder #(
  parameter int NUM_THREADS = 512,
  parameter int IDX_W       = $clog2(NUM_THREADS)
) (
  input  logic [NUM_THREADS-1:0] vec_i,
  output logic [IDX_W-1:0]       idx_o,
  output logic                   any_o
);

  localparam int LV = IDX_W;
  localparam int P  = 1 << LV;

  logic [P-1:0] vec_pad;
  assign vec_pad = P'(vec_i);

  for (genvar l = 0; l <= LV; l++) begin : g_lvl
    localparam int W = P >> l;
    logic [W-1:0]  any;
    logic [LV-1:0] idx [W];
    if (l == 0) begin : g_leaf
      assign any = vec_pad;
      for (genvar n = 0; n < W; n++) begin : g_n
        assign idx[n] = '0;
      end
    end else begin : g_node
      for (genvar n = 0; n < W; n++) begin : g_n
        assign any[n] = g_lvl[l-1].any[2*n]
                      | g_lvl[l-1].any[2*n+1];
        assign idx[n] = g_lvl[l-1].any[2*n]
                      ? g_lvl[l-1].idx[2*n]
                      : (g_lvl[l-1].idx[2*n+1]
                         | (LV'(1) << (l-1)));
      end
    end
  end

  assign any_o = g_lvl[LV].any[0];
  assign idx_o = g_lvl[LV].idx[0];

endmodule

// File: rtl/dice_thread_dispatcher.sv
// Thread-issue stage: streams active thread IDs of a launch in
// ascending order, one per cycle, on a valid/ready interface.
module dice_thread_dispatcher
  import dice_dispatch_pkg::*;
#(
  parameter int NUM_THREADS = DISP_NUM_THREADS,
  parameter int TID_WIDTH   = $clog2(NUM_THREADS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_valid,
  output logic                   start_ready,
  input  logic [TID_WIDTH:0]     start_count,
  input  logic [NUM_THREADS-1:0] start_mask,
  input  logic                   kill,
  output logic                   disp_valid,
  input  logic                   disp_ready,
  output logic [TID_WIDTH-1:0]   disp_tid,
  output logic                   disp_last,
  output logic                   done,
  output logic                   busy,
  output logic [TID_WIDTH:0]     dispatched_count
);

  dispatch_state_e state_q, state_d;
  logic [NUM_THREADS-1:0] mask_q, mask_d;
  logic                   vld_q, vld_d;
  logic                   last_q, last_d;
  logic [TID_WIDTH-1:0]   tid_q, tid_d;
  logic [TID_WIDTH:0]     cnt_q, cnt_d;
  logic                   done_q;

  logic [TID_WIDTH:0]     cnt_c;
  logic [NUM_THREADS-1:0] lowmask;
  logic [NUM_THREADS-1:0] mask_clr;
  logic [TID_WIDTH-1:0]   lsb_idx;
  logic                   lsb_any;
  logic                   slot_free;

  dice_lsb_finder #(
    .NUM_THREADS (NUM_THREADS),
    .IDX_W       (TID_WIDTH)
  ) u_lsb (
    .vec_i (mask_q),
    .idx_o (lsb_idx),
    .any_o (lsb_any)
  );

  assign cnt_c = (start_count > (TID_WIDTH+1)'(NUM_THREADS))
               ? (TID_WIDTH+1)'(NUM_THREADS)
               : start_count;

  always_comb begin
    lowmask = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      lowmask[i] = (TID_WIDTH+1)'(i) < cnt_c;
    end
  end

  assign mask_clr  = mask_q & ~(NUM_THREADS'(1) << lsb_idx);
  assign slot_free = !vld_q || disp_ready;

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    vld_d   = vld_q;
    last_d  = last_q;
    tid_d   = tid_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_valid) begin
          mask_d  = start_mask & lowmask;
          cnt_d   = '0;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (kill) begin
          mask_d  = '0;
          vld_d   = 1'b0;
          last_d  = 1'b0;
          state_d = ST_DONE;
        end else begin
          if (vld_q && disp_ready) cnt_d = cnt_q + 1'b1;
          if (slot_free) begin
            if (lsb_any) begin
              tid_d  = lsb_idx;
              mask_d = mask_clr;
              vld_d  = 1'b1;
              last_d = (mask_clr == '0);
            end else begin
              // Final transfer edge only drops valid; completion follows.
              vld_d  = 1'b0;
              last_d = 1'b0;
              if (!vld_q) state_d = ST_DONE;
            end
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      tid_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      tid_q   <= tid_d;
      cnt_q   <= cnt_d;
      done_q  <= (state_d == ST_DONE);
    end
  end

  assign start_ready      = (state_q == ST_IDLE);
  assign busy             = (state_q != ST_IDLE);
  assign disp_valid       = vld_q;
  assign disp_tid         = tid_q;
  assign disp_last        = last_q;
  assign done             = done_q;
  assign dispatched_count = cnt_q;

endmodule

// File: tb/tb_dice_thread_dispatcher.sv
// Bench for dice_thread_dispatcher: directed and random launches
// against a queue-based model of the expected tid stream.
module tb_dice_thread_dispatcher;

  localparam int N  = 512;
  localparam int TW = 9;

  logic          clk = 1'b0;
  logic          reset;
  logic          start_valid;
  logic          start_ready;
  logic [TW:0]   start_count;
  logic [N-1:0]  start_mask;
  logic          kill;
  logic          disp_valid;
  logic          disp_ready;
  logic [TW-1:0] disp_tid;
  logic          disp_last;
  logic          done;
  logic          busy;
  logic [TW:0]   dispatched_count;

  int checks = 0;
  int errors = 0;

  dice_thread_dispatcher #(.NUM_THREADS(N)) dut (
    .clk              (clk),
    .reset            (reset),
    .start_valid      (start_valid),
    .start_ready      (start_ready),
    .start_count      (start_count),
    .start_mask       (start_mask),
    .kill             (kill),
    .disp_valid       (disp_valid),
    .disp_ready       (disp_ready),
    .disp_tid         (disp_tid),
    .disp_last        (disp_last),
    .done             (done),
    .busy             (busy),
    .dispatched_count (dispatched_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, disp_valid, 0);
    chk({tag, "_last"}, disp_last, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rdy"}, start_ready, 1);
  endtask

  // ready_pct: chance per cycle of disp_ready; kill_at: kill while the
  // offer following that many transfers is stalled (-1 = never).
  task automatic run_launch(input int cnt, input logic [N-1:0] m,
                            input int ready_pct, input int kill_at);
    int q[$];
    int lim, xfers, since, nexp;
    bit killed, v, r, seen_done;
    lim = (cnt > N) ? N : cnt;
    for (int i = 0; i < lim; i++) if (m[i]) q.push_back(i);
    nexp = q.size();
    xfers = 0; killed = 0; seen_done = 0;
    chk("pre_start_ready", start_ready, 1);
    start_valid = 1; start_count = cnt[TW:0]; start_mask = m;
    disp_ready = 0;
    step();
    start_valid = 0;
    since = 0;
    chk("e0_busy", busy, 1);
    chk("e0_valid", disp_valid, 0);
    chk("e0_count", dispatched_count, 0);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (done) begin
        seen_done = 1;
        break;
      end
      v = disp_valid;
      if (cyc == 1 && nexp > 0) chk("first_valid", v, 1);
      if (ready_pct == 100 && cyc >= 1 && q.size() > 0)
        chk("no_bubble", v, 1);
      if (v) begin
        if (q.size() == 0) chk("extra_valid", v, 0);
        else begin
          chk("tid", disp_tid, q[0]);
          chk("last", disp_last, q.size() == 1);
        end
      end
      if (kill_at >= 0 && xfers == kill_at && v) begin
        disp_ready = 0; kill = 1;
        step();
        kill = 0; killed = 1;
        chk("kill_done", done, 1);
        seen_done = done;
        break;
      end
      r = ($urandom_range(99) < ready_pct);
      disp_ready = r;
      step();
      if (v && r && q.size() > 0) begin
        void'(q.pop_front());
        xfers++;
        since = 0;
      end else since++;
    end
    disp_ready = 0;
    chk("done_seen", seen_done, 1);
    if (!killed) begin
      chk("done_latency", since, 1);
      chk("all_dispatched", q.size(), 0);
    end
    chk("count", dispatched_count, xfers);
    chk("done_valid", disp_valid, 0);
    chk("done_busy", busy, 1);
    chk("done_srdy", start_ready, 0);
    step();
    chk("post_done", done, 0);
    chk("post_srdy", start_ready, 1);
    chk("post_busy", busy, 0);
    chk("post_count", dispatched_count, xfers);
  endtask

  initial begin
    logic [N-1:0] m;
    reset = 1; start_valid = 0; start_count = '0; start_mask = '0;
    kill = 0; disp_ready = 0;
    step(); step();
    reset = 0;
    chk_idle("reset");
    chk("reset_tid", disp_tid, 0);
    chk("reset_cnt", dispatched_count, 0);

    m = '0; m[7:0] = 8'hA5;
    run_launch(8, m, 100, -1);
    m = '1;
    run_launch(4, m, 40, -1);
    run_launch(0, m, 100, -1);
    m = '0; m[3] = 1; m[511] = 1;
    run_launch(600, m, 100, -1);
    m = '1;
    run_launch(16, m, 100, 5);
    m = '0;
    run_launch(300, m, 100, -1);

    // reset mid-launch
    m = '1;
    start_valid = 1; start_count = 10'd20; start_mask = m;
    disp_ready = 1;
    step();
    start_valid = 0;
    step(); step(); step();
    reset = 1;
    step();
    reset = 0; disp_ready = 0;
    chk_idle("midreset");
    chk("midreset_tid", disp_tid, 0);
    chk("midreset_cnt", dispatched_count, 0);
    step();
    chk_idle("midreset2");
    m = '0; m[9:0] = 10'h30F;
    run_launch(10, m, 100, -1);

    for (int k = 0; k < 12; k++) begin
      int dens, c, rp, ka;
      dens = $urandom_range(100);
      for (int i = 0; i < N; i++) m[i] = ($urandom_range(99) < dens);
      c  = $urandom_range(600);
      rp = (k % 3 == 0) ? 100 : $urandom_range(90, 20);
      ka = (k % 4 == 3) ? $urandom_range(20) : -1;
      run_launch(c, m, rp, ka);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
